// File: rtl/race_pkg.sv
// Shared types and width helpers for the multi-lane start-light controller.
package race_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      GO    = 2'd2,
      DONE  = 2'd3
   } race_state_t;

   // Bits needed to count 0..ticks-1; never narrower than one bit.
   function automatic int TICK_W(input int ticks);
      int w;
      if (ticks > 1) begin
         w = $clog2(ticks);
      end else begin
         w = 1;
      end
      return w;
   endfunction

   // Bits needed for the step counter shared by the COUNT, GO and DONE phases.
   function automatic int STEP_W(input int amber_steps, input int go_steps, input int hold_steps);
      int m;
      int w;
      m = amber_steps;
      if (go_steps > m) begin
         m = go_steps;
      end else begin
         m = m;
      end
      if (hold_steps > m) begin
         m = hold_steps;
      end else begin
         m = m;
      end
      if (m > 1) begin
         w = $clog2(m);
      end else begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/race_tick_gen.sv
// Step-rate enable generator: one-cycle tick every TICKS_PER_STEP clocks,
// restartable so every light step starts at a full period.
module race_tick_gen
   import race_pkg::*;
#(
   parameter int TICKS_PER_STEP = 50_000_000
) (
   input  logic CLOCK,
   input  logic nRESET,
   input  logic clr,
   output logic tick
);

   localparam int              TW   = TICK_W(TICKS_PER_STEP);
   localparam logic [TW-1:0]   LAST = TW'(TICKS_PER_STEP - 1);

   logic [TW-1:0] cnt_r;

   assign tick = (cnt_r == LAST);

   // Period counter: wraps after the tick, restarts on every phase change.
   always_ff @(negedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
         cnt_r <= {TW{1'b0}};
      end else if (clr) begin
         cnt_r <= {TW{1'b0}};
      end else if (tick) begin
         cnt_r <= {TW{1'b0}};
      end else begin
         cnt_r <= cnt_r + TW'(1);
      end
   end

endmodule

// File: rtl/race_tree_multilane.sv
// Multi-lane start-light controller: amber countdown, green launch window,
// per-lane false-start detection and first-launch winner capture.
module race_tree_multilane
   import race_pkg::*;
#(
   parameter int LANES          = 2,
   parameter int AMBER_STEPS    = 3,
   parameter int TICKS_PER_STEP = 50_000_000,
   parameter int GO_STEPS       = 5,
   parameter int HOLD_STEPS     = 3
) (
   input  logic                   CLOCK,
   input  logic                   nRESET,
   input  logic                   START,
   input  logic [LANES-1:0]       lane_go,
   output logic                   red,
   output logic [AMBER_STEPS-1:0] amber,
   output logic                   green,
   output logic [LANES-1:0]       foul,
   output logic [LANES-1:0]       winner,
   output logic                   busy,
   output logic [1:0]             state
);

   localparam int            SW         = STEP_W(AMBER_STEPS, GO_STEPS, HOLD_STEPS);
   localparam logic [SW-1:0] AMBER_LAST = SW'(AMBER_STEPS - 1);
   localparam logic [SW-1:0] GO_LAST    = SW'(GO_STEPS - 1);
   localparam logic [SW-1:0] HOLD_LAST  = SW'(HOLD_STEPS - 1);

   race_state_t      state_r, state_s;
   logic [SW-1:0]    step_r, step_s;
   logic [LANES-1:0] foul_r, foul_s;
   logic [LANES-1:0] win_r, win_s;
   logic [LANES-1:0] fouled_s;
   logic [LANES-1:0] valid_s;
   logic             tick_s;
   logic             clr_s;

   race_tick_gen #(
      .TICKS_PER_STEP(TICKS_PER_STEP)
   ) u_tick (
      .CLOCK  (CLOCK),
      .nRESET (nRESET),
      .clr    (clr_s),
      .tick   (tick_s)
   );

   // Next-state, step and lane-result logic; fouls win over the COUNT->GO step.
   always_comb begin
      state_s  = state_r;
      step_s   = step_r;
      foul_s   = foul_r;
      win_s    = win_r;
      fouled_s = foul_r | lane_go;
      valid_s  = lane_go & ~foul_r;
      case (state_r)
         IDLE: begin
            if (START) begin
               state_s = COUNT;
               step_s  = {SW{1'b0}};
               foul_s  = {LANES{1'b0}};
               win_s   = {LANES{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         COUNT: begin
            foul_s = fouled_s;
            if (&fouled_s) begin
               state_s = DONE;
               step_s  = {SW{1'b0}};
            end else if (tick_s) begin
               if (step_r == AMBER_LAST) begin
                  state_s = GO;
                  step_s  = {SW{1'b0}};
               end else begin
                  step_s = step_r + SW'(1);
               end
            end else begin
               step_s = step_r;
            end
         end
         GO: begin
            if (|valid_s) begin
               win_s   = valid_s;
               state_s = DONE;
               step_s  = {SW{1'b0}};
            end else if (tick_s) begin
               if (step_r == GO_LAST) begin
                  state_s = DONE;
                  step_s  = {SW{1'b0}};
               end else begin
                  step_s = step_r + SW'(1);
               end
            end else begin
               step_s = step_r;
            end
         end
         DONE: begin
            if (tick_s) begin
               if (step_r == HOLD_LAST) begin
                  state_s = IDLE;
                  step_s  = {SW{1'b0}};
               end else begin
                  step_s = step_r + SW'(1);
               end
            end else begin
               step_s = step_r;
            end
         end
         default: begin
            state_s = IDLE;
            step_s  = {SW{1'b0}};
         end
      endcase
      clr_s = (state_s != state_r);
   end

   // State, step and lane-result registers.
   always_ff @(negedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
         state_r <= IDLE;
         step_r  <= {SW{1'b0}};
         foul_r  <= {LANES{1'b0}};
         win_r   <= {LANES{1'b0}};
      end else begin
         state_r <= state_s;
         step_r  <= step_s;
         foul_r  <= foul_s;
         win_r   <= win_s;
      end
   end

   // Moore lamp decode from the registered state and step.
   always_comb begin
      red   = (state_r == IDLE) || (state_r == DONE);
      green = (state_r == GO);
      busy  = (state_r == COUNT) || (state_r == GO);
      amber = {AMBER_STEPS{1'b0}};
      for (int k = 0; k < AMBER_STEPS; k++) begin
         amber[k] = (state_r == COUNT) && (step_r == SW'(k));
      end
   end

   assign foul   = foul_r;
   assign winner = win_r;
   assign state  = state_r;

endmodule
